// File: rtl/hex_display_pio.sv
// rtl/hex_display_pio.sv - Avalon-MM hex/raw seven-segment display PIO; optional blink under HEX_DISPLAY_PIO_BLINK_EN
module hex_display_pio #(
    parameter int DIGITS    = 2,
    parameter int DIGIT_W   = 8,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2:0]                address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
    output logic [31:0]               readdata,
    output logic [DIGITS*DIGIT_W-1:0] out_port
);

    localparam int DW = DIGITS * DIGIT_W;

    logic              w_wr;
    logic [DW-1:0]     w_wd;
    logic [DW-1:0]     r_data;
    logic [DIGITS-1:0] r_mode;
    logic [DIGITS-1:0] w_blink;
    logic              w_phase;
    logic [DW-1:0]     w_next;
    logic [DW-1:0]     r_out;
    logic              w_unused;

    assign w_wr     = chipselect & ~write_n;
    assign w_wd     = writedata[DW-1:0];
    assign w_unused = &{1'b0, writedata};

    // Active-low glyphs for hex digits 0-F, bit order gfedcba
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    // DATA and MODE registers, including the single-cycle set/clear aliases
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_mode <= '0;
        end else if (w_wr) begin
            case (address)
                3'd0: r_data <= w_wd;
                3'd1: r_mode <= writedata[DIGITS-1:0];
                3'd4: r_data <= r_data | w_wd;
                3'd5: r_data <= r_data & ~w_wd;
                default: ;
            endcase
        end
    end

`ifdef HEX_DISPLAY_PIO_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [DIGITS-1:0] r_blink;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_phase;

    // Free-running blink timer; a BLINK write restarts it so the new mask begins in the visible phase
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_wr && address == 3'd2) begin
            r_blink <= writedata[DIGITS-1:0];
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    assign w_blink = r_blink;
    assign w_phase = r_phase;
`else
    localparam int unused_blink_div = BLINK_DIV;

    assign w_blink = '0;
    assign w_phase = 1'b0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [DIGIT_W-1:0] w_raw;
        logic [DIGIT_W-1:0] w_dec;
        logic [DIGIT_W-1:0] w_sel;

        assign w_raw = r_data[g*DIGIT_W +: DIGIT_W];

        // Decoded digit: glyph in the low seven bits, dp and any extra bits held off
        always_comb begin
            w_dec      = '1;
            w_dec[6:0] = hex_glyph(w_raw[3:0]);
        end

        assign w_sel = (w_blink[g] & w_phase) ? '1 : (r_mode[g] ? w_dec : w_raw);
        assign w_next[g*DIGIT_W +: DIGIT_W] = w_sel;
    end

    // Registered segment drive; blank while in reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '1;
        end else begin
            r_out <= w_next;
        end
    end

    assign out_port = r_out;

    // Zero-wait-state read mux
    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata = 32'(r_data);
            3'd1: readdata = 32'(r_mode);
`ifdef HEX_DISPLAY_PIO_BLINK_EN
            3'd2: readdata = 32'(r_blink);
            3'd6: readdata = {31'b0, r_phase};
`endif
            default: readdata = '0;
        endcase
    end

endmodule
